// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO between instruction fetch and DC_stage, flushed on mispredict.
// Optional macro FQ_BYPASS_EN: an empty queue forwards the fetch offer to decode combinationally.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   f_valid,
  input  logic [31:0]            f_pc,
  input  logic [31:0]            f_inst,
  input  logic                   f_jump,
  output logic                   fq_ready,
  output logic                   IF_valid,
  output logic [31:0]            DC_in_pc,
  output logic [31:0]            DC_in_inst,
  output logic                   DC_in_jump,
  input  logic                   DC_ready,
  input  logic                   mispredict,
  output logic [$clog2(DEPTH):0] fq_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   inst_q [DEPTH];
  logic          jump_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic full, empty, push, wr_en, rd_en, bypass_hit;

  // fq_ready depends only on registered count, so a pop never frees a slot in the same cycle
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign fq_ready = !full && !mispredict;
  assign push     = f_valid && fq_ready;

`ifdef FQ_BYPASS_EN
  logic bypass_sel;
  assign bypass_sel = empty && f_valid && !mispredict;
  // consumed directly by decode: never written into storage
  assign bypass_hit = bypass_sel && DC_ready;
  assign IF_valid   = (!empty && !mispredict) || bypass_sel;
  assign DC_in_pc   = bypass_sel ? f_pc   : pc_q[head_q];
  assign DC_in_inst = bypass_sel ? f_inst : inst_q[head_q];
  assign DC_in_jump = bypass_sel ? f_jump : jump_q[head_q];
`else
  assign bypass_hit = 1'b0;
  assign IF_valid   = !empty && !mispredict;
  assign DC_in_pc   = pc_q[head_q];
  assign DC_in_inst = inst_q[head_q];
  assign DC_in_jump = jump_q[head_q];
`endif

  assign wr_en = push && !bypass_hit;
  assign rd_en = !empty && !mispredict && DC_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (mispredict) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) tail_d = tail_q + AW'(1);
      if (rd_en) head_d = head_q + AW'(1);
      count_d = count_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // storage is deliberately left intact by a flush; only pointers are cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
        jump_q[i] <= 1'b0;
      end
    end else if (wr_en) begin
      pc_q[tail_q]   <= f_pc;
      inst_q[tail_q] <= f_inst;
      jump_q[tail_q] <= f_jump;
    end
  end

  assign fq_count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          f_valid = 1'b0;
  logic [31:0]   f_pc = '0;
  logic [31:0]   f_inst = '0;
  logic          f_jump = 1'b0;
  logic          fq_ready;
  logic          IF_valid;
  logic [31:0]   DC_in_pc;
  logic [31:0]   DC_in_inst;
  logic          DC_in_jump;
  logic          DC_ready = 1'b0;
  logic          mispredict = 1'b0;
  logic [CW-1:0] fq_count;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .f_valid    (f_valid),
    .f_pc       (f_pc),
    .f_inst     (f_inst),
    .f_jump     (f_jump),
    .fq_ready   (fq_ready),
    .IF_valid   (IF_valid),
    .DC_in_pc   (DC_in_pc),
    .DC_in_inst (DC_in_inst),
    .DC_in_jump (DC_in_jump),
    .DC_ready   (DC_ready),
    .mispredict (mispredict),
    .fq_count   (fq_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: an ordered list of queued entries
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        jump;
  } ent_t;

  ent_t mq[$];

  always @(posedge clk or posedge rst) begin
    int   n;
    bit   byp;
    bit   take;
    ent_t e;
    if (rst) begin
      mq.delete();
    end else if (mispredict) begin
      mq.delete();
    end else begin
      n   = mq.size();
      byp = 1'b0;
`ifdef FQ_BYPASS_EN
      byp = (n == 0) && f_valid;
`endif
      take = ((n > 0) || byp) && DC_ready;
      if (!(byp && DC_ready)) begin
        if (take) void'(mq.pop_front());
        if (f_valid && (n < DEPTH)) begin
          e.pc   = f_pc;
          e.inst = f_inst;
          e.jump = f_jump;
          mq.push_back(e);
        end
      end
    end
  end

  logic [31:0] dut_log[$];
  bit          track = 1'b0;
  int          max_cnt = 0;

  // Every-cycle comparison of DUT against the model, away from the active edge
  always @(negedge clk) begin
    int          n;
    bit          ev;
    logic [31:0] epc, einst;
    logic        ejump;
    n     = mq.size();
    ev    = (n > 0) && !mispredict;
    epc   = '0;
    einst = '0;
    ejump = 1'b0;
    if (n > 0) begin
      epc   = mq[0].pc;
      einst = mq[0].inst;
      ejump = mq[0].jump;
    end
`ifdef FQ_BYPASS_EN
    if ((n == 0) && f_valid && !mispredict) begin
      ev    = 1'b1;
      epc   = f_pc;
      einst = f_inst;
      ejump = f_jump;
    end
`endif
    chk("cmp_fq_ready", 32'(fq_ready), 32'((n < DEPTH) && !mispredict));
    chk("cmp_if_valid", 32'(IF_valid), 32'(ev));
    chk("cmp_fq_count", 32'(fq_count), 32'(n));
    if (ev) begin
      chk("cmp_pc",   DC_in_pc,          epc);
      chk("cmp_inst", DC_in_inst,        einst);
      chk("cmp_jump", 32'(DC_in_jump),   32'(ejump));
    end
    if (!rst && IF_valid && DC_ready) dut_log.push_back(DC_in_pc);
    if (track && (int'(fq_count) > max_cnt)) max_cnt = int'(fq_count);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    mid();
    chk("rst_if_valid", 32'(IF_valid), 32'd0);
    chk("rst_fq_count", 32'(fq_count), 32'd0);
    chk("rst_fq_ready", 32'(fq_ready), 32'd1);
    chk("rst_pc",       DC_in_pc,      32'd0);
    chk("rst_inst",     DC_in_inst,    32'd0);
    chk("rst_jump",     32'(DC_in_jump), 32'd0);

    // single push with decode ready
    step();
    f_valid = 1'b1; f_pc = 32'h100; f_inst = 32'h0000_0013; f_jump = 1'b0; DC_ready = 1'b1;
    mid();
`ifdef FQ_BYPASS_EN
    chk("t1_bypass_valid", 32'(IF_valid), 32'd1);
    chk("t1_bypass_pc",    DC_in_pc,      32'h100);
`else
    chk("t1_not_yet_valid", 32'(IF_valid), 32'd0);
`endif
    step();
    f_valid = 1'b0;
    mid();
`ifdef FQ_BYPASS_EN
    chk("t1_after_valid", 32'(IF_valid), 32'd0);
    chk("t1_after_count", 32'(fq_count), 32'd0);
`else
    chk("t1_valid",  32'(IF_valid), 32'd1);
    chk("t1_pc",     DC_in_pc,      32'h100);
    chk("t1_inst",   DC_in_inst,    32'h0000_0013);
    chk("t1_count",  32'(fq_count), 32'd1);
`endif
    step();
    mid();
    chk("t1_drained_count", 32'(fq_count), 32'd0);

    // fill to DEPTH, then a refused fifth offer while decode pops
    step();
    dut_log.delete();
    DC_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      f_valid = 1'b1; f_pc = 32'(i * 4); f_inst = 32'hA000_0000 + 32'(i);
      step();
    end
    f_pc = 32'h10; f_inst = 32'hA000_0010; DC_ready = 1'b1;
    mid();
    chk("fill_count",    32'(fq_count), 32'd4);
    chk("fill_ready",    32'(fq_ready), 32'd0);
    chk("fill_head_pc",  DC_in_pc,      32'h0);
    step();
    f_valid = 1'b0; DC_ready = 1'b0;
    mid();
    chk("fill_count_after_refuse", 32'(fq_count), 32'd3);
    chk("fill_head_pc_after",      DC_in_pc,      32'h4);
    step();
    DC_ready = 1'b1;
    repeat (3) step();
    DC_ready = 1'b0;
    mid();
    chk("fill_drained", 32'(fq_count), 32'd0);
    chk("fill_log_size", 32'(dut_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("fill_log_order", (i < dut_log.size()) ? dut_log[i] : 32'hDEAD_BEEF, 32'(i * 4));

    // sustained push/pop through pointer wrap
    step();
    dut_log.delete();
    max_cnt = 0;
    track = 1'b1;
    DC_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      f_valid = 1'b1; f_pc = 32'(i * 4); f_inst = 32'hB000_0000 + 32'(i);
      step();
    end
    f_valid = 1'b0;
    step();
    step();
    track = 1'b0;
    chk("wrap_log_size", 32'(dut_log.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      chk("wrap_order", (i < dut_log.size()) ? dut_log[i] : 32'hDEAD_BEEF, 32'(i * 4));
`ifdef FQ_BYPASS_EN
    chk("wrap_max_count", 32'(max_cnt), 32'd0);
`else
    chk("wrap_max_count", 32'(max_cnt), 32'd1);
`endif

    // flush with a concurrent fetch offer
    DC_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      f_valid = 1'b1; f_pc = 32'h300 + 32'(i * 4); f_inst = 32'hC000_0000 + 32'(i);
      step();
    end
    dut_log.delete();
    f_pc = 32'h200; f_inst = 32'hC000_0200; mispredict = 1'b1;
    mid();
    chk("flush_count_before", 32'(fq_count), 32'd3);
    chk("flush_if_valid",     32'(IF_valid), 32'd0);
    chk("flush_fq_ready",     32'(fq_ready), 32'd0);
    step();
    mispredict = 1'b0;
    f_valid = 1'b1; f_pc = 32'h400; f_inst = 32'hC000_0400; DC_ready = 1'b1;
    mid();
    chk("flush_count_after", 32'(fq_count), 32'd0);
    chk("flush_ready_after", 32'(fq_ready), 32'd1);
    step();
    f_valid = 1'b0;
    step();
    mid();
    chk("flush_log_size", 32'(dut_log.size()), 32'd1);
    chk("flush_log_pc",   (dut_log.size() > 0) ? dut_log[0] : 32'hDEAD_BEEF, 32'h400);

    // asynchronous reset between edges with two entries queued
    step();
    DC_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      f_valid = 1'b1; f_pc = 32'h500 + 32'(i * 4); f_inst = 32'hD000_0000 + 32'(i);
      step();
    end
    f_valid = 1'b0;
    mid();
    chk("arst_count_before", 32'(fq_count), 32'd2);
    chk("arst_valid_before", 32'(IF_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid_now", 32'(IF_valid), 32'd0);
    chk("arst_count_now", 32'(fq_count), 32'd0);
    #1 rst = 1'b0;
    step();
    mid();
    chk("arst_count_after", 32'(fq_count), 32'd0);

    // jump flag ordering
    step();
    DC_ready = 1'b0;
    f_valid = 1'b1; f_pc = 32'h3C; f_inst = 32'hE000_003C; f_jump = 1'b0;
    step();
    f_pc = 32'h40; f_inst = 32'hE000_0040; f_jump = 1'b1;
    step();
    f_valid = 1'b0; f_jump = 1'b0;
    mid();
    chk("jump_first_flag", 32'(DC_in_jump), 32'd0);
    chk("jump_first_pc",   DC_in_pc,        32'h3C);
    step();
    DC_ready = 1'b1;
    step();
    mid();
    chk("jump_second_flag", 32'(DC_in_jump), 32'd1);
    chk("jump_second_pc",   DC_in_pc,        32'h40);
    step();
    DC_ready = 1'b0;
    mid();
    chk("jump_drained", 32'(fq_count), 32'd0);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
